window_scheduler: RTL

WINDOW_SCHEDULER -- requirements
Module: window_scheduler

---
 rtl/window_scheduler_pkg.sv | 12 +
 rtl/window_scheduler_tap_counter.sv | 40 ++++
 rtl/window_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/window_scheduler_pkg.sv
// Shared constants for the window scheduler and its tap counter.
// State encodings stay private to the blocks that use them.
package window_scheduler_pkg;

  localparam int DEFAULT_WIDTH  = 5;
  localparam int DEFAULT_ADDR_W = 5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/window_scheduler_tap_counter.sv
// Tap index within the current window: clears on request, and on enable
// either advances or wraps to zero once it reaches the terminal value.
module tap_counter
  import window_scheduler_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] last_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc_o    = (count_q == last_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/window_scheduler.sv
// Sliding-window address generator: walks filter taps over an input map,
// advancing the window base by the stride until the next window no longer fits.
module window_scheduler
  import window_scheduler_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  filter_size,
  input  logic [WIDTH-1:0]  stride,
  input  logic [ADDR_W-1:0] ifmap_len,
  input  logic              mac_ready,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] if_addr,
  output logic [WIDTH-1:0]  filt_addr,
  output logic              window_last,
  output logic              next_stride,
  output logic [ADDR_W-1:0] win_count,
  output logic              busy,
  output logic              done
);

  // Two spare bits so base+stride+filter_size can never wrap.
  localparam int SUM_W = max_int(ADDR_W, WIDTH) + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_FIN
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  fs_q;
  logic [WIDTH-1:0]  stride_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] win_q;

  logic              accept;
  logic              xfer;
  logic              fits;
  logic              no_window;
  logic [WIDTH-1:0]  tap;
  logic              tap_tc;
  logic [WIDTH-1:0]  tap_last;
  logic [ADDR_W-1:0] base_d;
  logic [WIDTH-1:0]  stride_d;

  assign accept    = (state_q == S_IDLE) && start;
  assign xfer      = (state_q == S_RUN) && mac_ready;
  assign tap_last  = fs_q - 1'b1;
  assign base_d    = base_q + ADDR_W'(stride_q);
  assign stride_d  = (stride == '0) ? WIDTH'(1) : stride;
  assign fits      = (SUM_W'(base_q) + SUM_W'(stride_q) + SUM_W'(fs_q)) <= SUM_W'(len_q);
  assign no_window = (filter_size == '0) || (SUM_W'(filter_size) > SUM_W'(ifmap_len));

  tap_counter #(
    .WIDTH(WIDTH)
  ) u_tap (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (xfer),
    .last_i (tap_last),
    .count_o(tap),
    .tc_o   (tap_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fs_q     <= '0;
      stride_q <= '0;
      len_q    <= '0;
      base_q   <= '0;
      win_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            fs_q     <= filter_size;
            stride_q <= stride_d;
            len_q    <= ifmap_len;
            base_q   <= '0;
            win_q    <= '0;
            state_q  <= no_window ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          if (mac_ready && tap_tc) begin
            win_q   <= win_q + 1'b1;
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          if (fits) begin
            base_q  <= base_d;
            state_q <= S_RUN;
          end else begin
            state_q <= S_FIN;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign addr_valid  = (state_q == S_RUN);
  assign if_addr     = base_q + ADDR_W'(tap);
  assign filt_addr   = tap;
  assign window_last = addr_valid && tap_tc;
  assign next_stride = (state_q == S_STEP) && fits;
  assign win_count   = win_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);

endmodule
